// File: rtl/instr_prefetch_pkg.sv
// Shared widths and sizing helpers for the instruction prefetch stage.
package instr_prefetch_pkg;

    localparam int unsigned WORD_WIDTH = 16;
    localparam int unsigned NIB_WIDTH  = 4;
    localparam int unsigned BYTE_WIDTH = 8;

    // Width of a counter that must hold 0..2*depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/instr_queue.sv
// In-order FIFO of {pc, word} pairs with push/pop/flush; push and pop may coincide at any fill level.
module instr_queue #(
    parameter int unsigned WordWidth = 16,
    parameter int unsigned Depth     = 4,
    localparam int unsigned CntW     = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [WordWidth-1:0] pc_i,
    input  logic [WordWidth-1:0] word_i,
    input  logic                 pop_i,
    input  logic                 flush_i,
    output logic [WordWidth-1:0] pc_o,
    output logic [WordWidth-1:0] word_o,
    output logic [CntW-1:0]      count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [WordWidth-1:0] pc_q   [Depth];
    logic [WordWidth-1:0] word_q [Depth];
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]      count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                pc_q[i]   <= '0;
                word_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) begin
                pc_q[wr_ptr_q]   <= pc_i;
                word_q[wr_ptr_q] <= word_i;
            end
        end
    end

    assign pc_o    = pc_q[rd_ptr_q];
    assign word_o  = word_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_prefetch.sv
// Prefetch stage: fetch counter, credit-gated request issue, stale-response drop, and decode queue.
module instr_prefetch #(
    parameter int unsigned WORD_WIDTH = instr_prefetch_pkg::WORD_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  do_reset_n,
    output logic                  mem_req,
    output logic [WORD_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    input  logic                  redirect,
    input  logic [WORD_WIDTH-1:0] redirect_addr,
    output logic                  instr_valid,
    output logic [WORD_WIDTH-1:0] instr,
    output logic [WORD_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
);
    import instr_prefetch_pkg::*;

    localparam int unsigned CntW  = cnt_width(DEPTH);
    localparam int unsigned QCntW = $clog2(DEPTH + 1);

    logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_WIDTH-1:0] ret_pc_q, ret_pc_d;
    logic [CntW-1:0]       inflight_q, inflight_d;
    logic [CntW-1:0]       drop_q, drop_d;
    logic [CntW-1:0]       credit;
    logic [QCntW-1:0]      q_count;
    logic                  q_full, q_empty;
    logic                  grant, drop_nz, discard, push, pop;

    // Live (non-stale) outstanding requests plus queued words bound the occupancy.
    assign credit  = CntW'(q_count) + inflight_q - drop_q;
    assign mem_req = do_reset_n & ~redirect & (credit < CntW'(DEPTH));
    assign mem_addr = fetch_pc_q;

    assign grant   = mem_req & mem_gnt;
    assign drop_nz = (drop_q != '0);
    assign discard = mem_rvalid & (drop_nz | redirect);
    assign push    = mem_rvalid & ~discard;
    assign pop     = instr_valid & instr_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        ret_pc_d   = ret_pc_q;
        inflight_d = inflight_q + CntW'(grant) - CntW'(mem_rvalid);
        drop_d     = drop_q;
        if (mem_rvalid && drop_nz) drop_d = drop_q - CntW'(1);
        if (grant) fetch_pc_d = fetch_pc_q + WORD_WIDTH'(1);
        if (push)  ret_pc_d   = ret_pc_q + WORD_WIDTH'(1);
        if (redirect) begin
            fetch_pc_d = redirect_addr;
            ret_pc_d   = redirect_addr;
            drop_d     = inflight_d;
        end
    end

    always_ff @(posedge clk or negedge do_reset_n) begin
        if (!do_reset_n) begin
            fetch_pc_q <= WORD_WIDTH'(RESET_ADDR);
            ret_pc_q   <= WORD_WIDTH'(RESET_ADDR);
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            ret_pc_q   <= ret_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    instr_queue #(
        .WordWidth (WORD_WIDTH),
        .Depth     (DEPTH)
    ) u_queue (
        .clk_i   (clk),
        .rst_ni  (do_reset_n),
        .push_i  (push),
        .pc_i    (ret_pc_q),
        .word_i  (mem_rdata),
        .pop_i   (pop),
        .flush_i (redirect),
        .pc_o    (instr_pc),
        .word_o  (instr),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign instr_valid = ~q_empty;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (do_reset_n) begin
            assert (!(push && q_full && !pop))
                else $error("instr_prefetch: response would overflow the queue");
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Scoreboard bench for instr_prefetch: a bench-side memory model tags requests by redirect epoch.
module tb_instr_prefetch;

    logic        clk = 1'b0;
    logic        do_reset_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;

    instr_prefetch #(
        .WORD_WIDTH (16),
        .DEPTH      (4),
        .RESET_ADDR (0)
    ) dut (
        .clk           (clk),
        .do_reset_n    (do_reset_n),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          due;
        int          epoch;
    } req_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] word;
    } exp_t;

    req_t        pend[$];
    exp_t        exp_q[$];
    logic [15:0] pop_log[$];
    logic [15:0] model_pc;
    logic [15:0] last_gnt_addr;
    int          epoch;
    int          cycle;
    int          lat;
    int          n_checks;
    int          n_errors;
    int          n_grants;
    int          n_pops;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int live_cnt();
        int n = 0;
        foreach (pend[i]) if (pend[i].epoch == epoch) n++;
        return n;
    endfunction

    // One cycle, entered and left at the falling edge.
    task automatic step(input logic rd, input logic [15:0] raddr, input logic rdy);
        exp_t e;
        req_t r;
        logic exp_req;
        redirect      = rd;
        redirect_addr = raddr;
        instr_ready   = rdy;
        mem_gnt       = 1'b1;
        if (pend.size() > 0 && pend[0].due <= cycle) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend[0].addr + 16'h1000;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 16'hdead;
        end
        #1;
        exp_req = !rd && ((exp_q.size() + live_cnt()) < 4);
        check_eq("mem_req", 32'(mem_req), 32'(exp_req));
        check_eq("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        if (instr_valid && rdy && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("instr_pc", 32'(instr_pc), 32'(e.pc));
            check_eq("instr", 32'(instr), 32'(e.word));
            pop_log.push_back(instr_pc);
            n_pops++;
        end
        if (mem_rvalid) begin
            r = pend.pop_front();
            if (r.epoch == epoch && !rd) exp_q.push_back('{pc: r.addr, word: r.addr + 16'h1000});
        end
        if (mem_req && mem_gnt) begin
            check_eq("mem_addr", 32'(mem_addr), 32'(model_pc));
            pend.push_back('{addr: model_pc, due: cycle + lat, epoch: epoch});
            last_gnt_addr = mem_addr;
            model_pc      = model_pc + 16'd1;
            n_grants++;
        end
        if (rd) begin
            exp_q.delete();
            epoch++;
            model_pc = raddr;
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    task automatic clear_model();
        pend.delete();
        exp_q.delete();
        pop_log.delete();
        epoch++;
        model_pc   = 16'h0000;
        mem_rvalid = 1'b0;
        redirect   = 1'b0;
        n_grants   = 0;
        n_pops     = 0;
    endtask

    task automatic do_reset();
        do_reset_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        do_reset_n = 1'b1;
    endtask

    initial begin
        bit found;
        n_checks      = 0;
        n_errors      = 0;
        epoch         = 0;
        cycle         = 0;
        lat           = 1;
        mem_gnt       = 1'b1;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        redirect      = 1'b0;
        redirect_addr = '0;
        instr_ready   = 1'b1;
        do_reset_n    = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'h0000);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", 32'(instr), 32'h0000);
        check_eq("rst_instr_pc", 32'(instr_pc), 32'h0000);
        @(negedge clk);
        do_reset_n = 1'b1;

        // Streaming at 1-cycle latency: one instruction per cycle, no gaps.
        lat = 1;
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        n_pops = 0;
        for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b1);
        check_eq("stream_pops", 32'(n_pops), 32'd20);

        // Reset mid-stream drops instr_valid immediately.
        #1;
        check_eq("pre_rst_valid", 32'(instr_valid), 32'd1);
        #1;
        do_reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(instr_valid), 32'd0);
        check_eq("mid_rst_req", 32'(mem_req), 32'd0);
        check_eq("mid_rst_addr", 32'(mem_addr), 32'h0000);
        @(negedge clk);
        do_reset();

        // Backpressure: exactly four grants, then fetching stalls.
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b0);
        check_eq("bp_grants", 32'(n_grants), 32'd4);
        #1;
        check_eq("bp_req_low", 32'(mem_req), 32'd0);
        check_eq("bp_valid", 32'(instr_valid), 32'd1);
        n_grants = 0;
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        check_eq("bp_resume_grants", 32'(n_grants), 32'd1);
        check_eq("bp_resume_addr", 32'(last_gnt_addr), 32'h0004);
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1);
        check_eq("bp_pop0", 32'(pop_log[0]), 32'h0000);
        check_eq("bp_pop3", 32'(pop_log[3]), 32'h0003);
        check_eq("bp_pop4", 32'(pop_log[4]), 32'h0004);

        // Redirect with two requests in flight at latency 3.
        do_reset();
        lat = 3;
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        check_eq("rd_inflight", 32'(live_cnt()), 32'd2);
        step(1'b1, 16'h0040, 1'b1);
        pop_log.delete();
        for (int i = 0; i < 15; i++) step(1'b0, 16'h0, 1'b1);
        check_eq("rd_first_pc", 32'(pop_log.size() > 0 ? pop_log[0] : 16'hffff), 32'h0040);

        // Redirect together with a response and a pop while the queue is as full as credit allows.
        do_reset();
        lat   = 2;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (exp_q.size() == 3 && pend.size() > 0 && pend[0].due <= cycle) found = 1'b1;
            else step(1'b0, 16'h0, 1'b0);
        end
        check_eq("full_setup", 32'(found), 32'd1);
        n_pops = 0;
        step(1'b1, 16'h0080, 1'b1);
        check_eq("full_rd_pop", 32'(n_pops), 32'd1);
        #1;
        check_eq("full_rd_empty", 32'(instr_valid), 32'd0);
        #1;
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1);

        // Address wrap after a redirect near the top of the address space.
        lat = 1;
        step(1'b1, 16'hfffe, 1'b1);
        pop_log.delete();
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b1);
        check_eq("wrap_n", 32'(pop_log.size() >= 3), 32'd1);
        if (pop_log.size() >= 3) begin
            check_eq("wrap_pc0", 32'(pop_log[0]), 32'hfffe);
            check_eq("wrap_pc1", 32'(pop_log[1]), 32'hffff);
            check_eq("wrap_pc2", 32'(pop_log[2]), 32'h0000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
